// File: rtl/tmds_pkg.sv
// Shared types and constants for HDMI-style TMDS period sequencing.
// Guard-band words are consumed by the downstream TMDS output mux.
package tmds_pkg;

   typedef enum logic [1:0] {
      CTRL     = 2'd0,
      PREAMBLE = 2'd1,
      GUARD    = 2'd2,
      VIDEO    = 2'd3
   } tmds_period_t;

   localparam logic [1:0] CTL_PREAMBLE_VIDEO = 2'b01;
   localparam logic [1:0] CTL_IDLE           = 2'b00;

   localparam logic [9:0] GB_CH0 = 10'b1011001100;
   localparam logic [9:0] GB_CH1 = 10'b0100110011;
   localparam logic [9:0] GB_CH2 = 10'b1011001100;

   // {de, vsync, hsync, red, green, blue}
   localparam int DL_WIDTH = 27;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/tmds_delay_line.sv
// Fixed-depth shift register with asynchronous active-low clear.
// The output is the oldest stage, DEPTH clocks behind d_in.
module tmds_delay_line #(
   parameter int WIDTH = 27,
   parameter int DEPTH = 10
) (
   input  logic             clk_in,
   input  logic             rst_in,
   input  logic [WIDTH-1:0] d_in,
   output logic [WIDTH-1:0] q_out
);

   logic [WIDTH-1:0] stage_q [DEPTH];

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
         stage_q[0] <= d_in;
         for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
   end

   assign q_out = stage_q[DEPTH-1];

endmodule

// File: rtl/tmds_period_sequencer.sv
// Control / preamble / guard-band / video period sequencing ahead of the
// three TMDS encoders; pixels and syncs are delayed so the preamble fits in blanking.
module tmds_period_sequencer
   import tmds_pkg::*;
#(
   parameter int PREAMBLE_LEN = 8,
   parameter int GUARD_LEN    = 2
) (
   input  logic         clk_in,
   input  logic         rst_in,
   input  logic         de_in,
   input  logic         hsync_in,
   input  logic         vsync_in,
   input  logic [7:0]   red_in,
   input  logic [7:0]   green_in,
   input  logic [7:0]   blue_in,
   output logic         ve_out,
   output logic [1:0]   ctrl0_out,
   output logic [1:0]   ctrl1_out,
   output logic [1:0]   ctrl2_out,
   output logic [7:0]   blue_out,
   output logic [7:0]   green_out,
   output logic [7:0]   red_out,
   output logic         gb_sel_out,
   output logic         err_out,
   output tmds_period_t dbg_state_out
);

   localparam int D     = PREAMBLE_LEN + GUARD_LEN;
   localparam int CNT_W = $clog2(max_int(PREAMBLE_LEN, GUARD_LEN)) + 1;
   localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(PREAMBLE_LEN - 1);
   localparam logic [CNT_W-1:0] GRD_LAST = CNT_W'(GUARD_LEN - 1);

   logic [DL_WIDTH-1:0] tap;
   logic                de_d, vs_d, hs_d;
   logic [7:0]          r_d, g_d, b_d;

   tmds_period_t     state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             err_q, err_d;
   logic             de_prev_q, de_rise;
   logic             gb_q;
   logic [1:0]       ctrl0_q;
   logic [7:0]       red_q, green_q, blue_q;

   tmds_delay_line #(.WIDTH(DL_WIDTH), .DEPTH(D)) u_delay (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .d_in   ({de_in, vsync_in, hsync_in, red_in, green_in, blue_in}),
      .q_out  (tap)
   );

   assign {de_d, vs_d, hs_d, r_d, g_d, b_d} = tap;
   assign de_rise = de_in & ~de_prev_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      case (state_q)
         CTRL: begin
            // Delayed video with no preamble behind it is blanked, never sequenced.
            if (de_d) begin
               err_d = 1'b1;
            end else if (de_rise) begin
               state_d = PREAMBLE;
               cnt_d   = '0;
            end
         end
         PREAMBLE: begin
            if (de_rise) err_d = 1'b1;
            if (cnt_q == PRE_LAST) begin
               state_d = GUARD;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         GUARD: begin
            if (de_rise) err_d = 1'b1;
            if (cnt_q == GRD_LAST) begin
               state_d = de_d ? VIDEO : CTRL;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         VIDEO: begin
            if (de_rise) err_d = 1'b1;
            if (!de_d) state_d = CTRL;
         end
         default: state_d = CTRL;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_in) begin
      if (!rst_in) begin
         state_q   <= CTRL;
         cnt_q     <= '0;
         err_q     <= 1'b0;
         // A line already in progress at reset release must not look like a new rise.
         de_prev_q <= 1'b1;
         gb_q      <= 1'b0;
         ctrl0_q   <= 2'b00;
         red_q     <= 8'h00;
         green_q   <= 8'h00;
         blue_q    <= 8'h00;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         err_q     <= err_d;
         de_prev_q <= de_in;
         gb_q      <= (state_q == GUARD);
         ctrl0_q   <= {vs_d, hs_d};
         red_q     <= (state_d == VIDEO) ? r_d : 8'h00;
         green_q   <= (state_d == VIDEO) ? g_d : 8'h00;
         blue_q    <= (state_d == VIDEO) ? b_d : 8'h00;
      end
   end

   assign ve_out        = (state_q == VIDEO);
   assign ctrl1_out     = (state_q == PREAMBLE) ? CTL_PREAMBLE_VIDEO : CTL_IDLE;
   assign ctrl2_out     = CTL_IDLE;
   assign ctrl0_out     = ctrl0_q;
   assign red_out       = red_q;
   assign green_out     = green_q;
   assign blue_out      = blue_q;
   assign gb_sel_out    = gb_q;
   assign err_out       = err_q;
   assign dbg_state_out = state_q;

endmodule

// File: tb/tb_tmds_period_sequencer.sv
// Bench for tmds_period_sequencer: a vector table for idle and two normal lines,
// then hand-written sequences for the single-pixel, short-blanking and reset cases.
module tb_tmds_period_sequencer;
   import tmds_pkg::*;

   logic         clk_in = 1'b0;
   logic         rst_in = 1'b0;
   logic         de_in = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
   logic [7:0]   red_in = 8'h00, green_in = 8'h00, blue_in = 8'h00;
   logic         ve_out, gb_sel_out, err_out;
   logic [1:0]   ctrl0_out, ctrl1_out, ctrl2_out;
   logic [7:0]   red_out, green_out, blue_out;
   tmds_period_t dbg_state_out;

   int n_cmp = 0;
   int n_err = 0;

   tmds_period_sequencer dut (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .de_in         (de_in),
      .hsync_in      (hsync_in),
      .vsync_in      (vsync_in),
      .red_in        (red_in),
      .green_in      (green_in),
      .blue_in       (blue_in),
      .ve_out        (ve_out),
      .ctrl0_out     (ctrl0_out),
      .ctrl1_out     (ctrl1_out),
      .ctrl2_out     (ctrl2_out),
      .blue_out      (blue_out),
      .green_out     (green_out),
      .red_out       (red_out),
      .gb_sel_out    (gb_sel_out),
      .err_out       (err_out),
      .dbg_state_out (dbg_state_out)
   );

   always #5 clk_in = ~clk_in;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic       de, hs, vs;
      logic [7:0] r, g, b;
      logic       ve, gb, err;
      logic [1:0] c0, c1, c2;
      logic [7:0] er, eg, eb;
   } vec_t;

   localparam int N_VEC = 130;
   vec_t vecs[N_VEC];

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic drive(input logic de, input logic hs, input logic vs,
                        input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
      de_in = de; hsync_in = hs; vsync_in = vs;
      red_in = r; green_in = g; blue_in = b;
   endtask

   task automatic check(input string name, input int idx,
                        input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
      end
   endtask

   function automatic logic [32:0] all_outs();
      return {ve_out, gb_sel_out, err_out, ctrl0_out, ctrl1_out, ctrl2_out,
              red_out, green_out, blue_out};
   endfunction

   initial begin
      int s;
      int starts[2];
      int k;

      // Reset state
      drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      repeat (3) tick();
      check("reset_outputs", 0, 64'(all_outs()), 64'd0);
      check("reset_state", 0, 64'(dbg_state_out), 64'(CTRL));
      rst_in = 1'b1;

      // Table: idle with toggling hsync, line A at 20, line B at 80 with vsync high
      starts[0] = 20;
      starts[1] = 80;
      for (int i = 0; i < N_VEC; i++) begin
         logic in_a, in_b;
         in_a = (i >= 20 && i < 40);
         in_b = (i >= 80 && i < 100);
         vecs[i].de = in_a | in_b;
         vecs[i].hs = (in_a | in_b) ? 1'b0 : 1'((i / 2) % 2);
         vecs[i].vs = (i >= 75 && i < 105);
         if (in_a) begin
            vecs[i].g = 8'(8'h10 + (i - 20));
            vecs[i].r = 8'(8'h30 + (i - 20));
            vecs[i].b = 8'(8'h50 + (i - 20));
         end else if (in_b) begin
            vecs[i].g = 8'(8'hA0 + (i - 80));
            vecs[i].r = 8'(8'hC0 + (i - 80));
            vecs[i].b = 8'(8'h60 + (i - 80));
         end else begin
            vecs[i].g = 8'(8'hE0 ^ i);
            vecs[i].r = 8'(8'h0F ^ i);
            vecs[i].b = 8'(8'hF3 ^ i);
         end
      end
      for (int i = 0; i < N_VEC; i++) begin
         vecs[i].ve = 1'b0; vecs[i].gb = 1'b0; vecs[i].err = 1'b0;
         vecs[i].c1 = 2'b00; vecs[i].c2 = 2'b00;
         vecs[i].er = 8'h00; vecs[i].eg = 8'h00; vecs[i].eb = 8'h00;
         vecs[i].c0 = (i >= 10) ? {vecs[i-10].vs, vecs[i-10].hs} : 2'b00;
         for (int j = 0; j < 2; j++) begin
            s = starts[j];
            if (i >= s && i <= s + 7) vecs[i].c1 = 2'b01;
            if (i == s + 9 || i == s + 10) vecs[i].gb = 1'b1;
            if (i >= s + 10 && i <= s + 29) begin
               vecs[i].ve = 1'b1;
               vecs[i].er = vecs[i-10].r;
               vecs[i].eg = vecs[i-10].g;
               vecs[i].eb = vecs[i-10].b;
            end
         end
      end
      for (int i = 0; i < N_VEC; i++) begin
         drive(vecs[i].de, vecs[i].hs, vecs[i].vs, vecs[i].r, vecs[i].g, vecs[i].b);
         tick();
         check("table", i, 64'(all_outs()),
               64'({vecs[i].ve, vecs[i].gb, vecs[i].err, vecs[i].c0, vecs[i].c1,
                    vecs[i].c2, vecs[i].er, vecs[i].eg, vecs[i].eb}));
      end

      // Single-cycle de pulse carrying pixel 0xAA
      for (int i = 0; i < 15; i++) begin
         if (i == 0) drive(1'b1, 1'b0, 1'b0, 8'hAA, 8'hAA, 8'hAA);
         else        drive(1'b0, 1'b0, 1'b0, 8'h55, 8'h55, 8'h55);
         tick();
         check("pulse", i, 64'({ctrl1_out, gb_sel_out, ve_out, red_out, green_out, blue_out}),
               64'({(i <= 7) ? 2'b01 : 2'b00, 1'(i == 9 || i == 10), 1'(i == 10),
                    (i == 10) ? 24'hAAAAAA : 24'h000000}));
      end

      // Blanking of 5 cycles between two 6-pixel runs
      for (int i = 0; i < 41; i++) begin
         if (i < 6)       drive(1'b1, 1'b0, 1'b0, 8'h00, 8'(8'h60 + i), 8'h00);
         else if (i < 11) drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
         else if (i < 17) drive(1'b1, 1'b0, 1'b0, 8'h00, 8'(8'h70 + i), 8'h00);
         else             drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
         tick();
         k = i - 10;
         check("short_blank", i, 64'({ve_out, err_out, gb_sel_out, ctrl1_out, green_out}),
               64'({1'(i >= 10 && i <= 15), 1'(i >= 11), 1'(i == 9 || i == 10),
                    (i <= 7) ? 2'b01 : 2'b00,
                    (i >= 10 && i <= 15) ? 8'(8'h60 + k) : 8'h00}));
      end

      // Reset asserted mid-VIDEO with err already set
      for (int i = 0; i < 13; i++) begin
         drive(1'b1, 1'b1, 1'b1, 8'h11, 8'(8'h90 + i), 8'h22);
         tick();
      end
      check("pre_reset_video", 0, 64'({ve_out, err_out, green_out}), 64'({1'b1, 1'b1, 8'h92}));
      #2;
      rst_in = 1'b0;
      #1;
      check("async_reset_outputs", 0, 64'(all_outs()), 64'd0);
      tick();
      rst_in = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(1'(i < 5), 1'b0, 1'b0, 8'(8'hB0 + i), 8'(8'hC0 + i), 8'(8'hE0 + i));
         tick();
         check("post_reset", i, 64'({ve_out, err_out, gb_sel_out, ctrl1_out, red_out, green_out, blue_out}),
               64'({1'b0, 1'(i >= 10), 1'b0, 2'b00, 24'h000000}));
      end
      for (int i = 0; i < 30; i++) begin
         drive(1'(i < 4), 1'b0, 1'b0, 8'h00, 8'(8'hD0 + i), 8'h00);
         tick();
         k = i - 10;
         check("recover_line", i, 64'({ve_out, err_out, gb_sel_out, ctrl1_out, green_out}),
               64'({1'(i >= 10 && i <= 13), 1'b1, 1'(i == 9 || i == 10),
                    (i <= 7) ? 2'b01 : 2'b00,
                    (i >= 10 && i <= 13) ? 8'(8'hD0 + k) : 8'h00}));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/tmds_period_sequencer.md
Name: tmds_period_sequencer

Overview:
- Sits between the video timing/pixel pipeline and the three tmds_encoder instances (blue = ch0, green = ch1, red = ch2).
- Turns raw de/hsync/vsync/RGB into per-channel ve_in, control_in and data_in, giving HDMI-style period sequencing: control period, 8-cycle video preamble, 2-cycle video guard band, then active video.
- Delays pixels and syncs internally so the preamble and guard band fit in blanking ahead of each active run.
- Drives a guard-band select that the downstream TMDS mux uses to replace encoder output with fixed guard-band words.

Parameters:
- PREAMBLE_LEN, 8, preamble length in cycles.
- GUARD_LEN, 2, guard-band length in cycles.
- Internal delay depth D = PREAMBLE_LEN + GUARD_LEN; it is not a separate parameter.

Ports:
- clk_in input 1: pixel clock.
- rst_in input 1: asynchronous, active-low reset.
- de_in input 1: display enable, undelayed.
- hsync_in input 1: horizontal sync.
- vsync_in input 1: vertical sync.
- red_in input 8: pixel data, red.
- green_in input 8: pixel data, green.
- blue_in input 8: pixel data, blue.
- ve_out input/output: output 1: video enable to all three encoders.
- ctrl0_out output 2: control_in for ch0, {vsync, hsync}.
- ctrl1_out output 2: control_in for ch1, {CTL1, CTL0}.
- ctrl2_out output 2: control_in for ch2, {CTL3, CTL2}.
- blue_out output 8: data_in for ch0.
- green_out output 8: data_in for ch1.
- red_out output 8: data_in for ch2.
- gb_sel_out output 1: guard-band select, aligned to encoder tmds_out (one cycle after the GUARD slot).
- err_out output 1: sticky timing-violation flag.

Behaviour:
- Reset (rst_in = 0, asynchronous):
  - All outputs 0.
  - State CTRL, counter 0.
  - Delay line cleared (de/syncs/pixels 0).
  - err_out cleared. This is the only way to clear it.
- Delay line: de/hsync/vsync/RGB are delayed D cycles. The _d suffix below denotes delayed values. Data outputs are registered from the delay tap.
- FSM, one state update per clock:
  - CTRL:
    - ve_out = 0, ctrl1_out = 00, ctrl2_out = 00.
    - On a de_in rising edge (de_in = 1, previous de_in = 0): go to PREAMBLE, counter = 0.
  - PREAMBLE:
    - ve_out = 0, ctrl1_out = 01, ctrl2_out = 00.
    - Stays PREAMBLE_LEN cycles, then goes to GUARD, counter = 0.
  - GUARD:
    - ve_out = 0; ctrl1/ctrl2 = 00.
    - Stays GUARD_LEN cycles, then goes to VIDEO.
    - Guard-band flag is registered so gb_sel_out is high for exactly GUARD_LEN cycles, lagging by one clock.
  - VIDEO:
    - ve_out = 1; ctrl1/ctrl2 = 00.
    - Data outputs equal the delayed RGB.
    - When de_d = 0, go to CTRL in the same cycle, so ve_out drops with de_d.
- Common to all states:
  - ctrl0_out = {vsync_d, hsync_d}.
  - Data outputs are 0 whenever ve_out = 0.
- Alignment: the first VIDEO cycle coincides with the first de_d = 1 cycle, which is exactly D cycles after the de_in rise.
- Boundary conditions:
  - de_in rise while the state is not CTRL (blanking shorter than D): set err_out. The rise is ignored and no new preamble starts. If de_d later goes 1 while in CTRL, the pixels are blanked (ve_out = 0) until de_d falls.
  - de_d = 1 while in CTRL (e.g. reset released mid-line): remain in CTRL, blank the pixels, set err_out.
  - de_in high for a single cycle: the full preamble and guard band are emitted, followed by one VIDEO cycle.
  - Reset mid-operation: immediate return to the reset state. The delay line is flushed, so no stale video appears.
  - Counter width: clog2(max(PREAMBLE_LEN, GUARD_LEN)) + 1 bits. It wraps only on restart.

Decomposition:
- Package tmds_pkg holds:
  - typedef enum {CTRL, PREAMBLE, GUARD, VIDEO} tmds_period_t.
  - CTL_PREAMBLE_VIDEO = 2'b01, CTL_IDLE = 2'b00.
  - Guard-band words GB_CH0 = 10'b1011001100, GB_CH1 = 10'b0100110011, GB_CH2 = 10'b1011001100 (used by the mux downstream).
- Sub-module tmds_delay_line, parameters WIDTH and DEPTH: a shift register with async active-low clear. It carries {de, vsync, hsync, r, g, b} at 27 bits.

Test Plan:
- Reset then idle with de_in = 0 and hsync_in toggling: ve_out = 0, ctrl1 = ctrl2 = 00, and ctrl0_out[0] follows hsync_in 10 cycles later. err_out = 0.
- de_in rises at cycle t with 20 pixels 0x10..0x23 and blanking of 40 between lines:
  - ctrl1_out = 01 for t+0..t+7.
  - gb_sel_out = 1 at t+9 and t+10.
  - ve_out = 1 for t+10..t+29, with green_out = 0x10 at t+10.
  - ve_out = 0 at t+30.
- Blanking of only 5 cycles between two active runs: err_out asserts the cycle after the second de_in rise. The second run's pixels are blanked, and ve_out stays 0 for that run.
- de_in pulse of 1 cycle, pixel 0xAA: 8 preamble cycles, 2 gb_sel cycles, exactly 1 ve_out cycle with data 0xAA.
- rst_in pulsed low mid-VIDEO: all outputs go 0 immediately. After release with de_in already high, data stays blanked and err_out = 1 once de_d = 1. The next full line sequences normally.
- vsync_in = 1 during a line: ctrl0_out = 2'b1x throughout CTRL and PREAMBLE, delayed 10 cycles. Video output is unaffected.
